// File: rtl/m2s_req_rsp_bridge_if.sv
// Handshake bundle between the DP side, the bridge and the VPI co-simulation side.
// The bridge uses the slave modport; the surrounding environment uses master.
interface m2s_req_rsp_bridge_if #(
  parameter int TID_WIDTH  = 16,
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 32
);
  localparam int REQ_W = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int RSP_W = TID_WIDTH + DATA_WIDTH;

  logic             dp_req_valid;
  logic             dp_req_ready;
  logic [REQ_W-1:0] dp_req_data;
  logic             vpi_req_valid;
  logic             vpi_req_ready;
  logic [REQ_W-1:0] vpi_req_data;
  logic             vpi_rsp_valid;
  logic             vpi_rsp_ready;
  logic [RSP_W-1:0] vpi_rsp_data;
  logic             dp_rsp_valid;
  logic             dp_rsp_ready;
  logic [RSP_W-1:0] dp_rsp_data;

  modport slave (
    input  dp_req_valid, dp_req_data, vpi_req_ready,
    input  vpi_rsp_valid, vpi_rsp_data, dp_rsp_ready,
    output dp_req_ready, vpi_req_valid, vpi_req_data,
    output vpi_rsp_ready, dp_rsp_valid, dp_rsp_data
  );

  modport master (
    output dp_req_valid, dp_req_data, vpi_req_ready,
    output vpi_rsp_valid, vpi_rsp_data, dp_rsp_ready,
    input  dp_req_ready, vpi_req_valid, vpi_req_data,
    input  vpi_rsp_ready, dp_rsp_valid, dp_rsp_data
  );
endinterface

// File: rtl/m2s_req_rsp_bridge.sv
// DP <-> VPI request/response bridge: two show-ahead FIFOs, outstanding limiter, sticky errors.
// Optional in-order TID tracker enabled by defining M2S_BRIDGE_TID_CHECK_EN.
module m2s_req_rsp_bridge #(
  parameter int TID_WIDTH       = 16,
  parameter int ADDR_WIDTH      = 31,
  parameter int DATA_WIDTH      = 32,
  parameter int REQ_DEPTH       = 16,
  parameter int RSP_DEPTH       = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  m2s_req_rsp_bridge_if.slave                bus,
  output logic [$clog2(REQ_DEPTH):0]         req_count,
  output logic [$clog2(RSP_DEPTH):0]         rsp_count,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  input  logic                               err_clr,
  output logic                               err_drop,
  output logic                               err_orphan,
  output logic                               err_tid
);
  localparam int REQ_W  = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int RSP_W  = TID_WIDTH + DATA_WIDTH;
  localparam int REQ_AW = $clog2(REQ_DEPTH);
  localparam int RSP_AW = $clog2(RSP_DEPTH);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [REQ_AW:0]  REQ_FULL = (REQ_AW + 1)'(REQ_DEPTH);
  localparam logic [RSP_AW:0]  RSP_FULL = (RSP_AW + 1)'(RSP_DEPTH);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

  logic [REQ_W-1:0]  r_reqMem [REQ_DEPTH];
  logic [REQ_AW-1:0] r_reqWr, r_reqRd;
  logic [REQ_AW:0]   r_reqCnt;
  logic [RSP_W-1:0]  r_rspMem [RSP_DEPTH];
  logic [RSP_AW-1:0] r_rspWr, r_rspRd;
  logic [RSP_AW:0]   r_rspCnt;
  logic [OUT_W-1:0]  r_outstanding;
  logic              r_errDrop, r_errOrphan;

  logic w_reqFull, w_reqEmpty, w_reqPush, w_reqPop;
  logic w_rspFull, w_rspEmpty, w_rspPush, w_rspPop;
  logic w_rspOrphan, w_rspRetire, w_dropSet;

  // Ready depends only on registered state, so a pop at full frees space one cycle later.
  assign w_reqFull          = (r_reqCnt == REQ_FULL);
  assign w_reqEmpty         = (r_reqCnt == '0);
  assign bus.dp_req_ready   = !w_reqFull && (r_outstanding < OUT_MAX);
  assign bus.vpi_req_valid  = !w_reqEmpty;
  assign bus.vpi_req_data   = r_reqMem[r_reqRd];
  assign w_reqPush          = bus.dp_req_valid && bus.dp_req_ready;
  assign w_reqPop           = !w_reqEmpty && bus.vpi_req_ready;

  assign w_rspFull          = (r_rspCnt == RSP_FULL);
  assign w_rspEmpty         = (r_rspCnt == '0);
  assign bus.vpi_rsp_ready  = !w_rspFull;
  assign bus.dp_rsp_valid   = !w_rspEmpty;
  assign bus.dp_rsp_data    = r_rspMem[r_rspRd];
  assign w_rspPush          = bus.vpi_rsp_valid && bus.vpi_rsp_ready;
  assign w_rspPop           = !w_rspEmpty && bus.dp_rsp_ready;

  assign w_rspOrphan = w_rspPush && (r_outstanding == '0);
  assign w_rspRetire = w_rspPush && !w_rspOrphan;
  assign w_dropSet   = (bus.dp_req_valid && !bus.dp_req_ready) ||
                       (bus.vpi_rsp_valid && !bus.vpi_rsp_ready);

  assign req_count   = r_reqCnt;
  assign rsp_count   = r_rspCnt;
  assign outstanding = r_outstanding;
  assign err_drop    = r_errDrop;
  assign err_orphan  = r_errOrphan;

  // Storage arrays are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_reqPush) r_reqMem[r_reqWr] <= bus.dp_req_data;
    if (w_rspPush) r_rspMem[r_rspWr] <= bus.vpi_rsp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reqWr  <= '0;
      r_reqRd  <= '0;
      r_reqCnt <= '0;
      r_rspWr  <= '0;
      r_rspRd  <= '0;
      r_rspCnt <= '0;
    end else begin
      if (w_reqPush) r_reqWr <= r_reqWr + 1'b1;
      if (w_reqPop)  r_reqRd <= r_reqRd + 1'b1;
      if (w_rspPush) r_rspWr <= r_rspWr + 1'b1;
      if (w_rspPop)  r_rspRd <= r_rspRd + 1'b1;
      case ({w_reqPush, w_reqPop})
        2'b10:   r_reqCnt <= r_reqCnt + 1'b1;
        2'b01:   r_reqCnt <= r_reqCnt - 1'b1;
        default: r_reqCnt <= r_reqCnt;
      endcase
      case ({w_rspPush, w_rspPop})
        2'b10:   r_rspCnt <= r_rspCnt + 1'b1;
        2'b01:   r_rspCnt <= r_rspCnt - 1'b1;
        default: r_rspCnt <= r_rspCnt;
      endcase
    end
  end

  // An orphan response never retires a request, so outstanding cannot underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_reqPush, w_rspRetire})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // A set event in the same cycle takes priority over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errDrop   <= 1'b0;
      r_errOrphan <= 1'b0;
    end else begin
      if (w_dropSet)        r_errDrop <= 1'b1;
      else if (err_clr)     r_errDrop <= 1'b0;
      if (w_rspOrphan)      r_errOrphan <= 1'b1;
      else if (err_clr)     r_errOrphan <= 1'b0;
    end
  end

`ifdef M2S_BRIDGE_TID_CHECK_EN
  localparam int TRK_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [TRK_AW-1:0] TRK_LAST = TRK_AW'(MAX_OUTSTANDING - 1);

  logic [TID_WIDTH-1:0] r_trkMem [MAX_OUTSTANDING];
  logic [TRK_AW-1:0]    r_trkWr, r_trkRd;
  logic                 r_errTid;
  logic                 w_tidMismatch;

  // Tracker occupancy equals outstanding, so the limiter already prevents overflow.
  assign w_tidMismatch = w_rspRetire &&
                         (bus.vpi_rsp_data[RSP_W-1 -: TID_WIDTH] != r_trkMem[r_trkRd]);
  assign err_tid       = r_errTid;

  always_ff @(posedge clk) begin
    if (w_reqPush) r_trkMem[r_trkWr] <= bus.dp_req_data[REQ_W-1 -: TID_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trkWr  <= '0;
      r_trkRd  <= '0;
      r_errTid <= 1'b0;
    end else begin
      if (w_reqPush)   r_trkWr <= (r_trkWr == TRK_LAST) ? '0 : r_trkWr + 1'b1;
      if (w_rspRetire) r_trkRd <= (r_trkRd == TRK_LAST) ? '0 : r_trkRd + 1'b1;
      if (w_tidMismatch) r_errTid <= 1'b1;
      else if (err_clr)  r_errTid <= 1'b0;
    end
  end
`else
  assign err_tid = 1'b0;
`endif
endmodule

// File: doc/m2s_req_rsp_bridge.md
Name: m2s_req_rsp_bridge

Overview:
Parametrised bidirectional buffering bridge between the datapath (DP) and the VPI co-simulation side.
- Request channel: DP -> VPI, carrying TID, write flag, address and data.
- Response channel: VPI -> DP, carrying TID and data.
- Both channels are show-ahead valid/ready FIFOs with true full at DEPTH entries and exposed occupancy.
- An outstanding-transaction limiter throttles DP requests.
- Sticky error flags record protocol violations.

Parameters:
TID_WIDTH, 16, transaction ID width
ADDR_WIDTH, 31, request address width
DATA_WIDTH, 32, data width
REQ_DEPTH, 16, request FIFO entries (power of two, >=2)
RSP_DEPTH, 16, response FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 8, maximum accepted requests without a response (>=1)
Derived values:
- REQ_W = TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH
- RSP_W = TID_WIDTH+DATA_WIDTH
- The TID is the MSB field of each word.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
dp_req_valid  in  1  DP request offered
dp_req_ready  out  1  request accepted this cycle when valid&&ready
dp_req_data  in  REQ_W  request word
vpi_req_valid  out  1  request FIFO non-empty
vpi_req_ready  in  1  VPI pops head
vpi_req_data  out  REQ_W  request FIFO head (show-ahead)
vpi_rsp_valid  in  1  VPI response offered
vpi_rsp_ready  out  1  response FIFO not full
vpi_rsp_data  in  RSP_W  response word
dp_rsp_valid  out  1  response FIFO non-empty
dp_rsp_ready  in  1  DP pops head
dp_rsp_data  out  RSP_W  response FIFO head (show-ahead)
req_count  out  clog2(REQ_DEPTH)+1  request occupancy
rsp_count  out  clog2(RSP_DEPTH)+1  response occupancy
outstanding  out  clog2(MAX_OUTSTANDING)+1  accepted requests awaiting response
err_clr  in  1  synchronous clear of all sticky errors
err_drop  out  1  sticky: valid asserted while ready low on either input side
err_orphan  out  1  sticky: response accepted while outstanding==0
err_tid  out  1  sticky: TID mismatch (see Optional Feature)

Behaviour:
Reset:
- All pointers, counts and outstanding = 0; all err_* = 0.
- vpi_req_valid = dp_rsp_valid = 0.
- dp_req_ready = vpi_rsp_ready = 1.
- Data outputs are don't-care while their valid is low; RAM is not reset.
- Assertion mid-operation discards all contents immediately (asynchronous).

FIFO storage and flags (each FIFO):
- Register array; the write pointer advances on push, the read pointer on pop.
- Pointers wrap modulo DEPTH.
- full = (count==DEPTH); empty = (count==0).
- Head data is read combinationally from the read pointer.

Push/pop:
- Push = valid&&ready at a clk rising edge.
- Pop = head valid && downstream ready.
- Pop while empty is ignored (no pointer or count change).

Latency:
- A word pushed at edge N is visible on the output valid/data after edge N (1 cycle).
- Simultaneous push and pop leaves count unchanged, including at full when the pop is accepted.
- Full-to-ready path: ready is derived from the registered count only. A pop at full does not raise ready in the same cycle.

Request acceptance:
- dp_req_ready = !req_full && (outstanding < MAX_OUTSTANDING).
- Response side: vpi_rsp_ready = !rsp_full.

Outstanding counter:
- +1 on request push; -1 on response push when outstanding>0.
- Both in the same cycle: net 0.
- A response push at outstanding==0 sets err_orphan. The response is still stored and forwarded; outstanding stays 0.

Error flags:
- err_drop sets when (dp_req_valid && !dp_req_ready) or (vpi_rsp_valid && !vpi_rsp_ready). The offered word is not stored.
- err_clr clears all errors; a set event in the same cycle wins over err_clr.

Optional Feature:
Macro M2S_BRIDGE_TID_CHECK_EN.
- Defined:
  - An internal in-order TID FIFO (depth MAX_OUTSTANDING) records each accepted request's TID.
  - Each response push compares its TID to the tracker head and pops the tracker.
  - On mismatch, err_tid is set; the response is still forwarded.
  - An orphan response does not pop the tracker.
- Undefined: no tracker is built; err_tid is tied to 0.

Test Plan:
1. Reset, push 16 requests with TID=0..15 and vpi_req_ready=0, MAX_OUTSTANDING=16 -> req_count=16, dp_req_ready=0 after edge 16; pop all -> data returned in order 0..15, then vpi_req_valid=0, req_count=0.
2. Default MAX_OUTSTANDING=8: push 8 requests with no responses -> dp_req_ready=0 at outstanding=8 while req_count<16. Push one response -> outstanding=7, dp_req_ready=1 next cycle.
3. Full response FIFO (rsp_count=16) with simultaneous dp_rsp_ready=1 and vpi_rsp_valid=1 -> vpi_rsp_ready=0, err_drop=1, rsp_count=15. Pulse err_clr -> err_drop=0.
4. Response TID=0x00AA with outstanding=0 -> err_orphan=1, dp_rsp_valid=1 next cycle with data 0x00AA in the TID field, outstanding stays 0.
5. With M2S_BRIDGE_TID_CHECK_EN: requests TID 1 then 2, responses TID 2 then 1 -> err_tid=1 after the first response edge; both responses delivered. Without the macro -> err_tid stays 0.
6. Assert rst asynchronously with 5 entries queued -> counts, outstanding and valids drop to 0 before the next clk edge; after release, a new push/pop round-trip is correct.
